uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised, configurable-frame UART receiver for the low-power multi-clock communication system.
- Successor to the fixed 8-bit receiver, with:
  - data width set by parameter
  - runtime parity none/even/odd
  - 1 or 2 stop bits
  - 3-sample majority vote per bit
  - break detection
  - valid/ready output holding register with overrun flag
- Sits in the UART clock domain. Its output feeds the data synchroniser toward the system controller.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9
PRESC_W, 6, width of prescale input; oversampling ratio 8..2^PRESC_W-1

Ports:
CLK  in  1  receiver oversampling clock
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line; idle high; already synchronised to CLK
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
STOP2  in  1  1 = two stop bits
prescale  in  PRESC_W  CLK cycles per bit; must be even and >= 8
data_ready  in  1  consumer accepts P_DATA while data_valid = 1
P_DATA  out  DATA_WIDTH  received word, LSB received first
data_valid  out  1  P_DATA and frame flags are valid
PAR_ERR  out  1  frame flag: parity mismatch; qualified by data_valid
STP_ERR  out  1  frame flag: a stop bit sampled 0; qualified by data_valid
OVR_ERR  out  1  one-cycle pulse: completed frame dropped because holding register was full
BRK_DET  out  1  one-cycle pulse: break frame received
busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset: async, active-low, immediate.
  - All outputs return to 0, P_DATA = 0, FSM = IDLE, counters = 0.
  - Reset mid-frame discards the frame and the holding register.
- Config latch: PAR_EN, PAR_TYP, STOP2 and prescale are latched on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Edge counter:
  - Counts 0..prescale-1 within each bit, then wraps to 0.
  - The bit counter increments on wrap.
  - t0 is the cycle in IDLE where RX_IN = 0 is sampled; that cycle counts as edge 0.
- Sampling:
  - RX_IN is captured at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - The bit value is the majority of the three captures, decided at edge_cnt = prescale/2+2.
- FSM states and transitions:
  - IDLE: go to START when RX_IN = 0.
  - START: at decision, if majority = 1 it is a glitch: go to IDLE, no flags. Otherwise continue to end of bit, then DATA.
  - DATA: shift in DATA_WIDTH bits LSB first. Then go to PARITY if PAR_EN, else STOP.
  - PARITY:
    - Even: error if XOR(data, parity bit) = 1.
    - Odd: error if XOR(data, parity bit) = 0.
  - STOP: one or two bits per STOP2. Any stop bit sampled 0 sets STP_ERR for the frame.
  - Frame end: at the last stop bit's edge_cnt = prescale-1, go to DELIVER.
  - DELIVER: one cycle, then IDLE.
  - Break exception: if all data bits, the parity bit (if enabled) and the first stop bit are 0, DELIVER instead pulses BRK_DET. No word is delivered and PAR_ERR/STP_ERR are not set. The FSM then enters BRK_WAIT.
  - BRK_WAIT: stay until RX_IN = 1, then go to IDLE.
- Latency: data_valid rises on the clock edge t0 + F*prescale + 1, where F = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- Holding register and handshake:
  - A word transfers on any cycle with data_valid & data_ready. data_valid stays high and P_DATA, PAR_ERR and STP_ERR stay stable until that transfer.
  - Frames with errors are still delivered, with their flags set.
  - DELIVER with register empty, or full and data_ready = 1 in the same cycle: load the new word; data_valid stays or becomes 1.
  - DELIVER with register full and data_ready = 0: discard the new word, pulse OVR_ERR; the held word is unchanged.
- Back-to-back frames: IDLE accepts a new start bit in the cycle immediately after DELIVER.
- Widths: the parity XOR covers exactly DATA_WIDTH bits. Counter widths are PRESC_W for edge and 4 bits for bit index; the maximum frame is 13 bits.

Test Plan:
- Nominal, even parity: DATA_WIDTH = 8, prescale = 8, PAR_EN = 1, PAR_TYP = 0, STOP2 = 0. Send 0xA5 with parity 0, data_ready = 1. Required: data_valid at t0+89, P_DATA = 0xA5, PAR_ERR = 0, STP_ERR = 0, one-cycle valid.
- Parity, odd and two stop bits: PAR_TYP = 1, STOP2 = 1, send 0x3C with parity 0. Required: data_valid at t0+97, PAR_ERR = 1. Then send 0x3C with parity 1. Required: PAR_ERR = 0.
- Start glitch: prescale = 8, RX_IN low for 2 cycles, then high. Required: busy returns to 0 at t0+6, and data_valid, BRK_DET and OVR_ERR stay 0.
- Stop error and break:
  - Send 0x55 with stop bit 0. Required: data_valid = 1, STP_ERR = 1.
  - Hold RX_IN low for 20 bit times. Required: BRK_DET pulses once at the nominal frame end, no data_valid, busy held until RX_IN returns to 1.
- Overrun: data_ready = 0, send 0x11 then 0x22. Required: OVR_ERR pulses once at the second DELIVER and P_DATA stays 0x11. Raise data_ready during the third frame's DELIVER cycle. Required: 0x11 transfers, then 0x33 appears with data_valid kept at 1.
- Reset mid-frame and majority vote:
  - Assert RST mid-DATA. Required: all outputs 0 immediately, and the next frame 0x0F is received correctly.
  - Inject a single-cycle inverted pulse on the middle sample of each bit. Required: P_DATA unchanged.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable-frame UART receiver: runtime parity/stop config, 3-sample majority
// per bit, break detection, and a valid/ready holding register with overrun pulse.
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  OVR_ERR,
    output logic                  BRK_DET,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER,
        S_BRK_WAIT
    } state_t;

    state_t                  state_q;
    logic [PRESC_W-1:0]      edge_cnt_q;
    logic [PRESC_W-1:0]      edge_cnt_d;
    logic [3:0]              bit_cnt_q;
    logic [PRESC_W-1:0]      presc_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    stop2_q;
    logic                    s0_q;
    logic                    s1_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    frm_par_err_q;
    logic                    frm_stp_err_q;
    logic                    all_zero_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    valid_q;
    logic                    par_err_q;
    logic                    stp_err_q;
    logic                    ovr_q;
    logic                    brk_q;

    logic [PRESC_W-1:0]      half_w;
    logic                    at_samp0;
    logic                    at_samp1;
    logic                    at_decide;
    logic                    at_bit_end;
    logic                    maj;

    // The third capture is taken live, so the voted bit is acted on at the
    // same edge and its effect is visible from edge_cnt = prescale/2+2 on.
    always_comb begin
        half_w     = presc_q >> 1;
        at_samp0   = (edge_cnt_q == half_w - PRESC_W'(1));
        at_samp1   = (edge_cnt_q == half_w);
        at_decide  = (edge_cnt_q == half_w + PRESC_W'(1));
        at_bit_end = (edge_cnt_q == presc_q - PRESC_W'(1));
        maj        = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
        edge_cnt_d = at_bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            presc_q       <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            stop2_q       <= 1'b0;
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            shift_q       <= '0;
            frm_par_err_q <= 1'b0;
            frm_stp_err_q <= 1'b0;
            all_zero_q    <= 1'b0;
            p_data_q      <= '0;
            valid_q       <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            ovr_q         <= 1'b0;
            brk_q         <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            brk_q <= 1'b0;
            if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!RX_IN) begin
                        state_q       <= S_START;
                        edge_cnt_q    <= '0;
                        bit_cnt_q     <= '0;
                        presc_q       <= prescale;
                        par_en_q      <= PAR_EN;
                        par_typ_q     <= PAR_TYP;
                        stop2_q       <= STOP2;
                        frm_par_err_q <= 1'b0;
                        frm_stp_err_q <= 1'b0;
                        all_zero_q    <= 1'b1;
                    end
                end

                S_START, S_DATA, S_PARITY, S_STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_samp0) s0_q <= RX_IN;
                    if (at_samp1) s1_q <= RX_IN;

                    if (at_decide) begin
                        case (state_q)
                            S_START: if (maj) state_q <= S_IDLE;
                            S_DATA: begin
                                shift_q    <= {maj, shift_q[DATA_WIDTH-1:1]};
                                all_zero_q <= all_zero_q & ~maj;
                            end
                            S_PARITY: begin
                                frm_par_err_q <= (^shift_q) ^ maj ^ par_typ_q;
                                all_zero_q    <= all_zero_q & ~maj;
                            end
                            default: begin
                                if (!maj) frm_stp_err_q <= 1'b1;
                                if (bit_cnt_q == 4'd0) all_zero_q <= all_zero_q & ~maj;
                            end
                        endcase
                    end

                    if (at_bit_end) begin
                        case (state_q)
                            S_START: begin
                                state_q   <= S_DATA;
                                bit_cnt_q <= '0;
                            end
                            S_DATA: begin
                                if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= par_en_q ? S_PARITY : S_STOP;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 4'd1;
                                end
                            end
                            S_PARITY: begin
                                state_q   <= S_STOP;
                                bit_cnt_q <= '0;
                            end
                            default: begin
                                if (stop2_q && bit_cnt_q == 4'd0) begin
                                    bit_cnt_q <= 4'd1;
                                end else begin
                                    state_q <= S_DELIVER;
                                end
                            end
                        endcase
                    end
                end

                S_DELIVER: begin
                    if (all_zero_q) begin
                        brk_q   <= 1'b1;
                        state_q <= S_BRK_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                        if (!valid_q || data_ready) begin
                            p_data_q  <= shift_q;
                            par_err_q <= frm_par_err_q;
                            stp_err_q <= frm_stp_err_q;
                            valid_q   <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end

                S_BRK_WAIT: begin
                    if (RX_IN) state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign OVR_ERR    = ovr_q;
    assign BRK_DET    = brk_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: framing, parity, glitch, break, overrun,
// reset and majority-vote scenarios with hand-computed expectations.
module tb_uart_rx_cfg;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b1;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          data_ready = 1'b1;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          PAR_ERR;
    logic          STP_ERR;
    logic          OVR_ERR;
    logic          BRK_DET;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ovr_cnt = 0;
    int brk_cnt = 0;
    int vrise_cnt = 0;
    int ovr_cyc = -1;
    int brk_cyc = -1;
    logic valid_prev = 1'b0;

    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .prescale   (prescale),
        .data_ready (data_ready),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .OVR_ERR    (OVR_ERR),
        .BRK_DET    (BRK_DET),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (OVR_ERR === 1'b1) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
        if (BRK_DET === 1'b1) begin
            brk_cnt = brk_cnt + 1;
            brk_cyc = cyc;
        end
        if (data_valid === 1'b1 && valid_prev !== 1'b1) vrise_cnt = vrise_cnt + 1;
        valid_prev = data_valid;
    end

    // Drives one frame per the current bench config; first stop bit = stp.
    // inj inverts the line for the single cycle hit by the middle sample.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                              input logic inj, output int t0);
        logic fbits [13];
        int   nb;
        nb = 0;
        fbits[nb] = 1'b0; nb++;
        for (int i = 0; i < DW; i++) begin fbits[nb] = d[i]; nb++; end
        if (PAR_EN) begin fbits[nb] = par; nb++; end
        fbits[nb] = stp; nb++;
        if (STOP2) begin fbits[nb] = 1'b1; nb++; end
        t0 = cyc + 1;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < int'(prescale); c++) begin
                RX_IN = (inj && c == int'(prescale) / 2 + 1) ? ~fbits[k] : fbits[k];
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic wait_valid(input int lim, output int at);
        while (data_valid !== 1'b1 && cyc < lim) @(negedge CLK);
        at = (data_valid === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset;
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, data_valid, PAR_ERR, STP_ERR, OVR_ERR, BRK_DET} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, data_valid, PAR_ERR, STP_ERR, OVR_ERR, BRK_DET});
        end
        checks++;
        if (P_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_pdata: got %h expected 00", P_DATA);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        $display("test_reset done");
    endtask

    task automatic test_nominal;
        int t0, at;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; data_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, t0);
        wait_valid(t0 + 120, at);
        checks++;
        if (at !== t0 + 89) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected %0d", at - t0, 89);
        end
        checks++;
        if ({P_DATA, PAR_ERR, STP_ERR} !== {8'hA5, 2'b00}) begin
            errors++;
            $display("FAIL nominal_word: got %h/%b%b expected a5/00", P_DATA, PAR_ERR, STP_ERR);
        end
        @(negedge CLK);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL nominal_one_cycle: got valid %b expected 0", data_valid);
        end
        $display("test_nominal: word %h at t0+%0d", P_DATA, at - t0);
    endtask

    task automatic test_parity_odd;
        int t0, at;
        PAR_TYP = 1'b1; STOP2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, t0);
        wait_valid(t0 + 130, at);
        checks++;
        if (at !== t0 + 97) begin
            errors++;
            $display("FAIL odd_latency: got %0d expected %0d", at - t0, 97);
        end
        checks++;
        if ({P_DATA, PAR_ERR} !== {8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL odd_bad_parity: got %h/%b expected 3c/1", P_DATA, PAR_ERR);
        end
        repeat (3) @(negedge CLK);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, t0);
        wait_valid(t0 + 130, at);
        checks++;
        if ({P_DATA, PAR_ERR} !== {8'h3C, 1'b0} || at !== t0 + 97) begin
            errors++;
            $display("FAIL odd_good_parity: got %h/%b at %0d expected 3c/0 at 97",
                     P_DATA, PAR_ERR, at - t0);
        end
        PAR_TYP = 1'b0; STOP2 = 1'b0;
        repeat (3) @(negedge CLK);
        $display("test_parity_odd done");
    endtask

    task automatic test_glitch;
        int t0, v0, b0, o0;
        v0 = vrise_cnt; b0 = brk_cnt; o0 = ovr_cnt;
        t0 = cyc + 1;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        while (cyc < t0 + 5) @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hold: got %b expected 1 at t0+5", busy);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_drop: got %b expected 0 at t0+6", busy);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (vrise_cnt != v0 || brk_cnt != b0 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL glitch_no_events: got v%0d b%0d o%0d expected 0 0 0",
                     vrise_cnt - v0, brk_cnt - b0, ovr_cnt - o0);
        end
        $display("test_glitch done");
    endtask

    task automatic test_stop_break;
        int t0, at, v0, b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, t0);
        wait_valid(t0 + 120, at);
        checks++;
        if (at !== t0 + 89 || {P_DATA, STP_ERR, PAR_ERR} !== {8'h55, 2'b10}) begin
            errors++;
            $display("FAIL stop_err: got %h stp%b par%b at %0d expected 55 stp1 par0 at 89",
                     P_DATA, STP_ERR, PAR_ERR, at - t0);
        end
        repeat (3) @(negedge CLK);
        v0 = vrise_cnt; b0 = brk_cnt;
        t0 = cyc + 1;
        RX_IN = 1'b0;
        repeat (20 * 8) @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy_hold: got %b expected 1", busy);
        end
        checks++;
        if (brk_cnt - b0 != 1 || brk_cyc != t0 + 89) begin
            errors++;
            $display("FAIL break_pulse: got %0d pulses at %0d expected 1 at 89",
                     brk_cnt - b0, brk_cyc - t0);
        end
        checks++;
        if (vrise_cnt != v0) begin
            errors++;
            $display("FAIL break_no_valid: got %0d valids expected 0", vrise_cnt - v0);
        end
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got busy %b expected 0", busy);
        end
        $display("test_stop_break done");
    endtask

    task automatic test_overrun;
        int t0, at, o0;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, t0);
        wait_valid(t0 + 120, at);
        checks++;
        if (P_DATA !== 8'h11) begin
            errors++;
            $display("FAIL ovr_first: got %h expected 11", P_DATA);
        end
        o0 = ovr_cnt;
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, t0);
        while (cyc < t0 + 92) @(negedge CLK);
        checks++;
        if (ovr_cnt - o0 != 1 || ovr_cyc != t0 + 89) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d pulses at %0d expected 1 at 89",
                     ovr_cnt - o0, ovr_cyc - t0);
        end
        checks++;
        if ({P_DATA, data_valid} !== {8'h11, 1'b1}) begin
            errors++;
            $display("FAIL ovr_held: got %h/%b expected 11/1", P_DATA, data_valid);
        end
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, t0);
        while (cyc < t0 + 88) @(negedge CLK);
        checks++;
        if ({P_DATA, data_valid} !== {8'h11, 1'b1}) begin
            errors++;
            $display("FAIL ovr_before_xfer: got %h/%b expected 11/1", P_DATA, data_valid);
        end
        data_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if ({P_DATA, data_valid} !== {8'h33, 1'b1}) begin
            errors++;
            $display("FAIL ovr_reload: got %h/%b expected 33/1", P_DATA, data_valid);
        end
        @(negedge CLK);
        checks++;
        if (data_valid !== 1'b0 || ovr_cnt - o0 != 1) begin
            errors++;
            $display("FAIL ovr_drain: got valid %b ovr %0d expected 0 1",
                     data_valid, ovr_cnt - o0);
        end
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid;
        int t0, at;
        data_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, t0);
        wait_valid(t0 + 120, at);
        repeat (2) @(negedge CLK);
        RX_IN = 1'b0; repeat (8) @(negedge CLK);
        RX_IN = 1'b1; repeat (8) @(negedge CLK);
        RX_IN = 1'b0; repeat (12) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if ({P_DATA, busy, data_valid, PAR_ERR, STP_ERR, OVR_ERR, BRK_DET} !== 14'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h %b expected 00 000000", P_DATA,
                     {busy, data_valid, PAR_ERR, STP_ERR, OVR_ERR, BRK_DET});
        end
        @(negedge CLK);
        RX_IN = 1'b1;
        RST = 1'b1;
        data_ready = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, t0);
        wait_valid(t0 + 120, at);
        checks++;
        if (at !== t0 + 89 || {P_DATA, PAR_ERR, STP_ERR} !== {8'h0F, 2'b00}) begin
            errors++;
            $display("FAIL reset_recover: got %h/%b%b at %0d expected 0f/00 at 89",
                     P_DATA, PAR_ERR, STP_ERR, at - t0);
        end
        repeat (3) @(negedge CLK);
        $display("test_reset_mid done");
    endtask

    task automatic test_majority;
        int t0, at;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, t0);
        wait_valid(t0 + 120, at);
        checks++;
        if (at !== t0 + 89 || {P_DATA, PAR_ERR, STP_ERR} !== {8'hC3, 2'b00}) begin
            errors++;
            $display("FAIL majority: got %h/%b%b at %0d expected c3/00 at 89",
                     P_DATA, PAR_ERR, STP_ERR, at - t0);
        end
        repeat (3) @(negedge CLK);
        $display("test_majority done");
    endtask

    task automatic test_back_to_back;
        int t0, t1, at;
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, t0);
        while (cyc < t0 + 89) @(negedge CLK);
        checks++;
        if ({P_DATA, data_valid} !== {8'h96, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b expected 96/1", P_DATA, data_valid);
        end
        send_frame(8'h69, 1'b0, 1'b1, 1'b0, t1);
        wait_valid(t1 + 120, at);
        checks++;
        if (t1 !== t0 + 90 || at !== t1 + 89 || P_DATA !== 8'h69) begin
            errors++;
            $display("FAIL b2b_second: got %h at %0d (start %0d) expected 69 at 89 (start 90)",
                     P_DATA, at - t1, t1 - t0);
        end
        repeat (3) @(negedge CLK);
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_parity_odd();
        test_glitch();
        test_stop_break();
        test_overrun();
        test_reset_mid();
        test_majority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
